syn_dual_port: RTL and testbench

SYN_DUAL_PORT -- requirements
Module: syn_dual_port

---
 rtl/syn_dual_port_pkg.sv | 6 +
 rtl/syn_dual_port.sv | 49 ++++
 tb/tb_syn_dual_port.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/syn_dual_port_pkg.sv
// Shared sizing constants for the simple dual-port RAM.
package syn_dual_port_pkg;
    localparam int DATA_WIDTH_DEF = 8;
    localparam int ADDR_WIDTH_DEF = 4;
    localparam int DEPTH_DEF      = 2 ** ADDR_WIDTH_DEF;
endpackage

// File: rtl/syn_dual_port.sv
// Simple dual-port RAM: one write port, one registered read port, write-first
// on address collision, synchronous reset clears every word and the read register.
module syn_dual_port
    import syn_dual_port_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  read,
    input  logic                  write,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [ADDR_WIDTH-1:0] read_address,
    output logic [DATA_WIDTH-1:0] data_out
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic                  collide;

    assign collide = write && (write_address == read_address);

    // Bypass the incoming write so a same-address read returns the new word.
    always_comb begin
        data_out_d = data_out_q;
        if (read) begin
            data_out_d = collide ? data_in : mem_q[read_address];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            data_out_q <= '0;
        end else begin
            if (write) begin
                mem_q[write_address] <= data_in;
            end
            data_out_q <= data_out_d;
        end
    end

    assign data_out = data_out_q;
endmodule

// File: tb/tb_syn_dual_port.sv
// Directed bench for syn_dual_port: reference memory model checked every cycle
// plus literal expectations at the key points.
module tb_syn_dual_port;
    logic       clk;
    logic       reset;
    logic       read;
    logic       write;
    logic [7:0] data_in;
    logic [3:0] write_address;
    logic [3:0] read_address;
    logic [7:0] data_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [7:0] ref_mem [16];
    logic [7:0] ref_dout;
    bit         ref_valid = 0;

    syn_dual_port dut (
        .clk(clk),
        .reset(reset),
        .read(read),
        .write(write),
        .data_in(data_in),
        .write_address(write_address),
        .read_address(read_address),
        .data_out(data_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: what the RAM must hold and return after each edge.
    always @(posedge clk) begin
        if (reset) begin
            foreach (ref_mem[i]) ref_mem[i] = 8'h00;
            ref_dout  = 8'h00;
            ref_valid = 1;
        end else if (ref_valid) begin
            if (read) begin
                if (write && write_address == read_address) ref_dout = data_in;
                else ref_dout = ref_mem[read_address];
            end
            if (write) ref_mem[write_address] = data_in;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (ref_valid) begin
            n_cmp++;
            if (data_out !== ref_dout) begin
                n_bad++;
                $display("FAIL model_cycle t=%0t: data_out=%h required=%h", $time, data_out, ref_dout);
            end
        end
    end

    task automatic drive(input logic rst, input logic rd, input logic wr,
                         input logic [7:0] din, input logic [3:0] wa, input logic [3:0] ra);
        @(negedge clk);
        reset         = rst;
        read          = rd;
        write         = wr;
        data_in       = din;
        write_address = wa;
        read_address  = ra;
    endtask

    // Check data_out just after the edge that follows the last drive.
    task automatic check_lit(input string name, input logic [7:0] exp);
        @(posedge clk);
        #1;
        n_cmp++;
        if (data_out !== exp) begin
            n_bad++;
            $display("FAIL %s: data_out=%h required=%h", name, data_out, exp);
        end
    endtask

    initial begin
        reset = 1'b1; read = 1'b0; write = 1'b0;
        data_in = 8'h00; write_address = 4'd0; read_address = 4'd0;

        drive(1, 0, 0, 8'h00, 4'd0, 4'd0);
        check_lit("reset_dout", 8'h00);

        drive(0, 1, 0, 8'h00, 4'd0, 4'd5);
        check_lit("read5_after_reset", 8'h00);

        drive(0, 0, 1, 8'hA5, 4'd3, 4'd0);
        drive(0, 1, 0, 8'h00, 4'd0, 4'd3);
        check_lit("read3_A5", 8'hA5);
        drive(0, 0, 1, 8'h3C, 4'd15, 4'd0);
        drive(0, 1, 0, 8'h00, 4'd0, 4'd15);
        check_lit("read15_3C", 8'h3C);

        drive(0, 0, 1, 8'h11, 4'd7, 4'd0);
        drive(0, 1, 1, 8'h77, 4'd7, 4'd7);
        check_lit("write_first_7", 8'h77);
        drive(0, 1, 0, 8'h00, 4'd0, 4'd7);
        check_lit("read7_after", 8'h77);

        drive(0, 0, 1, 8'h99, 4'd9, 4'd0);
        drive(0, 1, 1, 8'h55, 4'd2, 4'd9);
        check_lit("diff_addr_read9", 8'h99);
        drive(0, 1, 0, 8'h00, 4'd0, 4'd2);
        check_lit("diff_addr_read2", 8'h55);

        drive(0, 1, 0, 8'h00, 4'd0, 4'd3);
        check_lit("hold_setup", 8'hA5);
        for (int k = 0; k < 3; k++) begin
            drive(0, 0, 0, 8'h00, 4'd0, 4'(k * 5 + 1));
            check_lit($sformatf("hold_%0d", k), 8'hA5);
        end

        for (int a = 0; a < 16; a++) begin
            drive(0, 0, 1, 8'($urandom_range(1, 255)), 4'(a), 4'd0);
        end
        for (int a = 0; a < 16; a += 5) begin
            drive(0, 1, 0, 8'h00, 4'd0, 4'(a));
        end

        drive(1, 1, 1, 8'hFF, 4'd0, 4'd0);
        check_lit("reset_midop_dout", 8'h00);
        for (int a = 0; a < 16; a++) begin
            drive(0, 1, 0, 8'h00, 4'd0, 4'(a));
            check_lit($sformatf("cleared_%0d", a), 8'h00);
        end

        drive(1, 0, 0, 8'h00, 4'd0, 4'd0);
        drive(0, 1, 1, 8'h42, 4'd0, 4'd0);
        check_lit("first_cycle_after_reset", 8'h42);
        drive(0, 1, 0, 8'h00, 4'd0, 4'd0);
        check_lit("read0_after_reset_write", 8'h42);

        drive(0, 0, 0, 8'h00, 4'd0, 4'd0);
        @(negedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
